seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports listed clock and reset first.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a run of num_seq sequences; accepted only in IDLE.
REQ-005 num_seq  input  4  sequences per run; 0 means 16; latched on accepted start.
REQ-006 hold  input  1  request sequencer pause while running.
REQ-007 abort  input  1  terminate current run.
REQ-008 seq_state  input  2  sequencer state: FIRST=2'b11, SECOND=2'b01, THIRD=2'b10; 2'b00 illegal.
REQ-009 seq_terminal  input  1  sequencer terminal flag (THIRD and leaving THIRD this edge).
REQ-010 pause  output  1  pause drive to sequencer.
REQ-011 restart  output  1  restart drive to sequencer.
REQ-012 busy  output  1  high when controller not IDLE.
REQ-013 done  output  1  one-cycle pulse on run completion.
REQ-014 count  output  5  completed sequences in current or last run.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 Controller states SHALL be IDLE, RUN, FLUSH.
REQ-017 IDLE: pause=1, restart=1; start=1 and abort=0 -> RUN, latch target (num_seq, 0->16), clear count to 0.
REQ-018 RUN: restart=0, pause=hold (combinational).
REQ-019 RUN with seq_terminal=1 and abort=0: count <= count+1; if count+1 == target -> IDLE and done=1 next cycle; else remain RUN.
REQ-020 RUN with abort=1 -> FLUSH regardless of hold or seq_terminal; count not incremented; no done pulse.
REQ-021 FLUSH: pause=0, restart=1 for exactly one cycle, then IDLE; count retains partial value.
REQ-022 abort in IDLE or FLUSH SHALL be ignored; start in RUN or FLUSH SHALL be ignored; start and abort together in IDLE: start ignored.
REQ-023 done SHALL be registered, high exactly one cycle, coincident with first IDLE cycle after final terminal.
REQ-024 busy SHALL equal (state != IDLE); pause, restart, busy combinational from state and hold.
REQ-025 count SHALL not wrap: maximum value 16 (5'b10000).
REQ-026 hold held indefinitely in RUN SHALL freeze progress with no count change and no timeout.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, count=0, done=0, err=0, checker history invalid, independent of clk.
REQ-028 During and after reset outputs SHALL be pause=1, restart=1, busy=0.
REQ-029 Reset mid-RUN SHALL discard target and count with no done pulse.

Configuration
REQ-030 Macro SEQ_CHECK_EN SHALL enable the protocol checker; undefined: checker logic absent, err constant 0.
REQ-031 With SEQ_CHECK_EN: register previous seq_state, pause, restart each cycle; history valid from second rising edge after reset release.
REQ-032 Expected state SHALL be: restart -> FIRST; else FIRST+!pause -> SECOND, SECOND+!pause -> THIRD, THIRD+!pause -> FIRST; else previous state.
REQ-033 err SHALL set when seq_state==2'b00 at any edge, or history valid and seq_state != expected; cleared only by reset.

Verification
REQ-034 Reset, start=1 num_seq=2, sequencer model, hold=0 -> states 11,01,10 repeat twice, count 1 then 2, done high one cycle, busy 0, err 0.
REQ-035 num_seq=0 -> exactly 16 terminals counted, count=16, single done pulse.
REQ-036 num_seq=3, hold=1 for 5 cycles in SECOND -> pause=1, seq_state stays 01, count unchanged, run completes after hold release.
REQ-037 num_seq=4, abort at count=1 in THIRD with seq_terminal=1 -> FLUSH one cycle (restart=1), IDLE, count=1, no done.
REQ-038 SEQ_CHECK_EN defined, model jumps FIRST->THIRD with pause=0 -> err=1 next edge and stays 1 until rst_n=0; undefined -> err=0.
REQ-039 rst_n low mid-RUN between edges -> busy=0, pause=1, restart=1, count=0 immediately, no done.

Source files
------------

// File: rtl/seq_ctrl_if.sv
// seq_ctrl handshake bundle: run control, sequencer feedback and status.
// master drives requests and sequencer state; slave is the controller.
interface seq_ctrl_if;
  logic       start;
  logic [3:0] num_seq;
  logic       hold;
  logic       abort;
  logic [1:0] seq_state;
  logic       seq_terminal;
  logic       pause;
  logic       restart;
  logic       busy;
  logic       done;
  logic [4:0] count;
  logic       err;

  modport master (
    output start, num_seq, hold, abort,
    output seq_state, seq_terminal,
    input  pause, restart, busy, done, count, err
  );

  modport slave (
    input  start, num_seq, hold, abort,
    input  seq_state, seq_terminal,
    output pause, restart, busy, done, count, err
  );
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: runs num_seq three-state sequencer cycles with hold/abort.
// Define SEQ_CHECK_EN to build the sequencer protocol checker (err).
module seq_ctrl (
  input  logic      clk,
  input  logic      rst_n,
  seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [4:0] tgt_q, tgt_d;
  logic [4:0] count_inc;
  logic       done_q, done_d;

  assign count_inc = count_q + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= 5'd0;
      tgt_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = RUN;
          count_d = 5'd0;
          tgt_d   = (bus.num_seq == 4'd0) ? 5'd16
                                          : {1'b0, bus.num_seq};
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = FLUSH;
        end else if (bus.seq_terminal &&
                     count_q != 5'd16) begin
          count_d = count_inc;
          if (count_inc == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer is frozen at FIRST whenever the controller is not running.
  assign bus.pause   = (state_q == RUN) ? bus.hold
                                        : (state_q == IDLE);
  assign bus.restart = (state_q != RUN);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.count   = count_q;

`ifdef SEQ_CHECK_EN
  logic [1:0] prev_st_q;
  logic       prev_pse_q;
  logic       prev_rst_q;
  logic       hist_q;
  logic       err_q, err_d;
  logic [1:0] exp_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_st_q  <= 2'b11;
      prev_pse_q <= 1'b1;
      prev_rst_q <= 1'b1;
      hist_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_st_q  <= bus.seq_state;
      prev_pse_q <= bus.pause;
      prev_rst_q <= bus.restart;
      hist_q     <= 1'b1;
      err_q      <= err_d;
    end
  end

  always_comb begin
    exp_st = prev_st_q;
    if (prev_rst_q) begin
      exp_st = 2'b11;
    end else if (!prev_pse_q) begin
      unique case (prev_st_q)
        2'b11:   exp_st = 2'b01;
        2'b01:   exp_st = 2'b10;
        2'b10:   exp_st = 2'b11;
        default: exp_st = prev_st_q;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (bus.seq_state == 2'b00)
      err_d = 1'b1;
    if (hist_q && bus.seq_state != exp_st)
      err_d = 1'b1;
  end

  assign bus.err = err_q;
`else
  logic unused_seq_state;
  assign unused_seq_state = ^bus.seq_state;
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: table-driven runs against a behavioural sequencer model,
// plus directed reset, ignore-rules and protocol-checker sequences.
module tb_seq_ctrl;

  logic clk;
  logic rst_n;
  logic jump;
  int   n_cmp;
  int   n_bad;

`ifdef SEQ_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  seq_ctrl_if bus ();

  seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sequencer: FIRST=11 -> SECOND=01 -> THIRD=10 -> FIRST.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.seq_state <= 2'b11;
    else if (bus.restart)
      bus.seq_state <= 2'b11;
    else if (jump)
      bus.seq_state <= 2'b10;
    else if (!bus.pause) begin
      case (bus.seq_state)
        2'b11:   bus.seq_state <= 2'b01;
        2'b01:   bus.seq_state <= 2'b10;
        default: bus.seq_state <= 2'b11;
      endcase
    end
  end

  assign bus.seq_terminal = (bus.seq_state == 2'b10) &&
                            !bus.pause && !bus.restart;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] nseq;
    int         hold_len;
    int         abort_cnt;
    int         exp_cnt;
    int         exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input int idx);
    int hl;
    int dones;
    int hcnt;
    bit prev_hold;
    bit pend_flush;
    bit ok;
    hl = v.hold_len;
    dones = 0;
    hcnt = 0;
    prev_hold = 0;
    pend_flush = 0;
    ok = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_seq = v.nseq;
    @(negedge clk);
    bus.start = 1'b0;
    chk($sformatf("v%0d_busy_start", idx), bus.busy, 1);
    chk($sformatf("v%0d_cnt_clr", idx), bus.count, 0);
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.done) dones++;
      if (prev_hold) begin
        chk("hold_state", bus.seq_state, 2'b01);
        chk("hold_count", bus.count, hcnt);
        chk("hold_pause", bus.pause, 1);
      end
      if (pend_flush) begin
        chk("flush_restart", bus.restart, 1);
        chk("flush_pause", bus.pause, 0);
        chk("flush_busy", bus.busy, 1);
        chk("flush_count", bus.count, v.abort_cnt);
        pend_flush = 0;
      end
      if (!bus.busy) begin
        ok = 1;
        break;
      end
      bus.abort = 1'b0;
      bus.hold  = 1'b0;
      prev_hold = 0;
      if (v.abort_cnt >= 0 && bus.seq_state == 2'b10 &&
          int'(bus.count) == v.abort_cnt) begin
        bus.abort  = 1'b1;
        pend_flush = 1;
      end else if (hl > 0 && bus.seq_state == 2'b01) begin
        bus.hold  = 1'b1;
        hl--;
        prev_hold = 1;
        hcnt = bus.count;
      end
    end
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    chk($sformatf("v%0d_finished", idx), ok, 1);
    chk($sformatf("v%0d_count", idx), bus.count, v.exp_cnt);
    chk($sformatf("v%0d_idle_pause", idx), bus.pause, 1);
    chk($sformatf("v%0d_idle_restart", idx), bus.restart, 1);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulses", idx), dones, v.exp_done);
    chk($sformatf("v%0d_done_low", idx), bus.done, 0);
    chk($sformatf("v%0d_hold_left", idx), hl, 0);
    chk($sformatf("v%0d_err", idx), bus.err, 0);
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_bad = 0;
    jump  = 1'b0;
    rst_n = 1'b0;
    bus.start   = 1'b0;
    bus.num_seq = 4'd0;
    bus.hold    = 1'b0;
    bus.abort   = 1'b0;

    vecs[0] = '{nseq: 4'd2, hold_len: 0, abort_cnt: -1,
                exp_cnt: 2, exp_done: 1};
    vecs[1] = '{nseq: 4'd0, hold_len: 0, abort_cnt: -1,
                exp_cnt: 16, exp_done: 1};
    vecs[2] = '{nseq: 4'd3, hold_len: 5, abort_cnt: -1,
                exp_cnt: 3, exp_done: 1};
    vecs[3] = '{nseq: 4'd4, hold_len: 0, abort_cnt: 1,
                exp_cnt: 1, exp_done: 0};
    vecs[4] = '{nseq: 4'd1, hold_len: 0, abort_cnt: -1,
                exp_cnt: 1, exp_done: 1};
    vecs[5] = '{nseq: 4'd5, hold_len: 0, abort_cnt: 3,
                exp_cnt: 3, exp_done: 0};

    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_pause", bus.pause, 1);
    chk("rst_restart", bus.restart, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start together with abort, and abort alone, are ignored in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.num_seq = 4'd2;
    @(negedge clk);
    chk("start_abort_idle", bus.busy, 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_idle", bus.busy, 0);
    bus.abort = 1'b0;

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], i);

    // reset asserted between edges in the middle of a run
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_seq = 4'd4;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.count == 5'd1) begin
        seen = 1;
        break;
      end
    end
    chk("midrun_reached", seen, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_pause", bus.pause, 1);
    chk("midrst_restart", bus.restart, 1);
    chk("midrst_count", bus.count, 0);
    chk("midrst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("postrst_quiet", seen, 0);

    // sequencer skips SECOND: FIRST -> THIRD with pause low
    bus.start   = 1'b1;
    bus.num_seq = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("jump_first", bus.seq_state, 2'b11);
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    chk("jump_third", bus.seq_state, 2'b10);
    chk("jump_err_pre", bus.err, 0);
    @(negedge clk);
    chk("jump_err_set", bus.err, EXP_ERR);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.busy) begin
        seen = 1;
        break;
      end
    end
    chk("jump_run_end", seen, 1);
    @(negedge clk);
    chk("jump_err_sticky", bus.err, EXP_ERR);
    rst_n = 1'b0;
    #1;
    chk("jump_err_clr", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
